// File: rtl/clock_pkg.sv
// Shared definitions for the digital-clock time path: FSM/field encoding and
// default wrap limits for the seconds, minutes and hours counters.
package clock_pkg;

    // State values double as the field_sel code driven to the display.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } state_t;

    localparam int DEF_SEC_MAX       = 59;
    localparam int DEF_MIN_MAX       = 59;
    localparam int DEF_HOUR_MAX      = 23;
    localparam int DEF_TIMEOUT_TICKS = 10;

endpackage

// File: rtl/clock_set_controller_if.sv
// Signal bundle between the button front-end / time counters and the
// clock set controller.
interface clock_set_controller_if;

    logic       tick_1hz;
    logic       set_btn;
    logic       inc_btn;
    logic [5:0] sec_val;
    logic [5:0] min_val;
    logic [4:0] hour_val;

    logic       sec_en;
    logic       min_en;
    logic       hour_en;
    logic       sec_load;
    logic       min_load;
    logic       hour_load;
    logic [5:0] ld_data;
    logic [1:0] field_sel;
    logic       blink;

    modport slave (
        input  tick_1hz, set_btn, inc_btn, sec_val, min_val, hour_val,
        output sec_en, min_en, hour_en, sec_load, min_load, hour_load,
               ld_data, field_sel, blink
    );

    modport master (
        output tick_1hz, set_btn, inc_btn, sec_val, min_val, hour_val,
        input  sec_en, min_en, hour_en, sec_load, min_load, hour_load,
               ld_data, field_sel, blink
    );

endinterface

// File: rtl/clock_set_controller_idle_timer.sv
// Idle-tick counter for the SET states; done stays high once the terminal
// count is reached until the counter is cleared.
module set_idle_timer #(
    parameter int TIMEOUT_TICKS = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic tick,
    output logic done
);

    localparam int W = $clog2(TIMEOUT_TICKS + 1);

    logic [W-1:0] count_q;

    assign done = (count_q == W'(TIMEOUT_TICKS));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (tick && !done) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/clock_set_controller.sv
// Run/set sequencer for the sec/min/hour counters: cascades 1 Hz enables in
// RUN, drives single-cycle load strobes from the buttons in the SET states.
module clock_set_controller
    import clock_pkg::*;
#(
    parameter int SEC_MAX       = DEF_SEC_MAX,
    parameter int MIN_MAX       = DEF_MIN_MAX,
    parameter int HOUR_MAX      = DEF_HOUR_MAX,
    parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
    input logic                   clk,
    input logic                   rst_n,
    clock_set_controller_if.slave bus
);

    localparam logic [5:0] SEC_MAX_V  = 6'(SEC_MAX);
    localparam logic [5:0] MIN_MAX_V  = 6'(MIN_MAX);
    localparam logic [4:0] HOUR_MAX_V = 5'(HOUR_MAX);

    // Compare against the limit rather than relying on width overflow.
    function automatic logic [5:0] wrap_inc(input logic [5:0] val, input logic [5:0] max_val);
        return (val == max_val) ? 6'd0 : val + 6'd1;
    endfunction

    state_t     state_q, state_d;
    logic       sec_en_q, min_en_q, hour_en_q;
    logic       sec_en_d, min_en_d, hour_en_d;
    logic       sec_load_q, min_load_q, hour_load_q;
    logic       sec_load_d, min_load_d, hour_load_d;
    logic [5:0] ld_data_q, ld_data_d;
    logic       blink_q, blink_d;
    logic       timer_clear, timer_tick, timeout;

    set_idle_timer #(
        .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) u_idle_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(timer_clear),
        .tick (timer_tick),
        .done (timeout)
    );

    // NOTE: every signal written here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        sec_en_d    = 1'b0;
        min_en_d    = 1'b0;
        hour_en_d   = 1'b0;
        sec_load_d  = 1'b0;
        min_load_d  = 1'b0;
        hour_load_d = 1'b0;
        ld_data_d   = 6'd0;

        case (state_q)
            RUN: begin
                sec_en_d  = bus.tick_1hz;
                min_en_d  = bus.tick_1hz && (bus.sec_val == SEC_MAX_V);
                hour_en_d = min_en_d && (bus.min_val == MIN_MAX_V);
                if (bus.set_btn) state_d = SET_HOUR;
            end
            default: begin
                // Timeout outranks the buttons; mode advance outranks increment.
                if (timeout) begin
                    state_d = RUN;
                end else if (bus.set_btn) begin
                    case (state_q)
                        SET_HOUR: state_d = SET_MIN;
                        SET_MIN:  state_d = SET_SEC;
                        default:  state_d = RUN;
                    endcase
                end else if (bus.inc_btn) begin
                    case (state_q)
                        SET_HOUR: begin
                            hour_load_d = 1'b1;
                            ld_data_d   = wrap_inc({1'b0, bus.hour_val}, {1'b0, HOUR_MAX_V});
                        end
                        SET_MIN: begin
                            min_load_d = 1'b1;
                            ld_data_d  = wrap_inc(bus.min_val, MIN_MAX_V);
                        end
                        default: begin
                            sec_load_d = 1'b1;
                            ld_data_d  = wrap_inc(bus.sec_val, SEC_MAX_V);
                        end
                    endcase
                end
            end
        endcase

        timer_clear = bus.set_btn || bus.inc_btn || (state_d != state_q) || (state_q == RUN);
        timer_tick  = bus.tick_1hz;

        if ((state_d != state_q) || (state_q == RUN)) begin
            blink_d = 1'b0;
        end else begin
            blink_d = blink_q ^ bus.tick_1hz;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            sec_en_q    <= 1'b0;
            min_en_q    <= 1'b0;
            hour_en_q   <= 1'b0;
            sec_load_q  <= 1'b0;
            min_load_q  <= 1'b0;
            hour_load_q <= 1'b0;
            ld_data_q   <= 6'd0;
            blink_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sec_en_q    <= sec_en_d;
            min_en_q    <= min_en_d;
            hour_en_q   <= hour_en_d;
            sec_load_q  <= sec_load_d;
            min_load_q  <= min_load_d;
            hour_load_q <= hour_load_d;
            ld_data_q   <= ld_data_d;
            blink_q     <= blink_d;
        end
    end

    assign bus.sec_en    = sec_en_q;
    assign bus.min_en    = min_en_q;
    assign bus.hour_en   = hour_en_q;
    assign bus.sec_load  = sec_load_q;
    assign bus.min_load  = min_load_q;
    assign bus.hour_load = hour_load_q;
    assign bus.ld_data   = ld_data_q;
    assign bus.field_sel = state_q;
    assign bus.blink     = blink_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed and randomized checks of clock_set_controller against a
// mode/idle/blink reference model of the run/set behaviour.
module tb_clock_set_controller;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    clock_set_controller_if bus();

    clock_set_controller dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    int v_sec, v_min, v_hour;
    int m_mode, m_idle;
    bit m_blink;

    logic       e_sec_en, e_min_en, e_hour_en;
    logic       e_sec_load, e_min_load, e_hour_load;
    logic [5:0] e_ld;
    logic [1:0] e_fs;
    logic       e_blink;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_idle = 0; m_blink = 0;
        e_sec_en = 0; e_min_en = 0; e_hour_en = 0;
        e_sec_load = 0; e_min_load = 0; e_hour_load = 0;
        e_ld = 0; e_fs = 0; e_blink = 0;
    endtask

    // Mode 0 is RUN, 1..3 edit hour/min/sec; idle counts ticks spent editing.
    task automatic model_step(input bit t, input bit s, input bit i);
        int nm;
        nm = m_mode;
        e_sec_en = 0; e_min_en = 0; e_hour_en = 0;
        e_sec_load = 0; e_min_load = 0; e_hour_load = 0;
        e_ld = 0;
        if (m_mode == 0) begin
            e_sec_en  = t;
            e_min_en  = t && (v_sec == 59);
            e_hour_en = e_min_en && (v_min == 59);
            if (s) nm = 1;
        end else if (m_idle >= 10) begin
            nm = 0;
        end else if (s) begin
            nm = (m_mode + 1) % 4;
        end else if (i) begin
            case (m_mode)
                1: begin e_hour_load = 1; e_ld = 6'((v_hour + 1) % 24); end
                2: begin e_min_load  = 1; e_ld = 6'((v_min + 1) % 60);  end
                default: begin e_sec_load = 1; e_ld = 6'((v_sec + 1) % 60); end
            endcase
        end
        if (nm != m_mode || nm == 0) begin
            m_idle = 0;
            m_blink = 0;
        end else begin
            if (s || i) m_idle = 0;
            else if (t) m_idle++;
            if (t) m_blink = ~m_blink;
        end
        m_mode  = nm;
        e_fs    = 2'(nm);
        e_blink = m_blink;
    endtask

    task automatic check_all();
        check("sec_en",    bus.sec_en,    e_sec_en);
        check("min_en",    bus.min_en,    e_min_en);
        check("hour_en",   bus.hour_en,   e_hour_en);
        check("sec_load",  bus.sec_load,  e_sec_load);
        check("min_load",  bus.min_load,  e_min_load);
        check("hour_load", bus.hour_load, e_hour_load);
        check("ld_data",   bus.ld_data,   e_ld);
        check("field_sel", bus.field_sel, e_fs);
        check("blink",     bus.blink,     e_blink);
    endtask

    // Called one time unit after a posedge: drive, clock, predict, compare.
    task automatic step(input bit t, input bit s, input bit i);
        bus.sec_val  = 6'(v_sec);
        bus.min_val  = 6'(v_min);
        bus.hour_val = 5'(v_hour);
        bus.tick_1hz = t;
        bus.set_btn  = s;
        bus.inc_btn  = i;
        @(posedge clk);
        model_step(t, s, i);
        #1;
        bus.tick_1hz = 0;
        bus.set_btn  = 0;
        bus.inc_btn  = 0;
        check_all();
    endtask

    initial begin
        v_sec = 0; v_min = 0; v_hour = 0;
        bus.tick_1hz = 0; bus.set_btn = 0; bus.inc_btn = 0;
        bus.sec_val = 0; bus.min_val = 0; bus.hour_val = 0;
        rst_n = 0;
        model_reset();
        #12;
        check_all();
        rst_n = 1;
        @(posedge clk); #1;

        // RUN cascade at full wrap, then seconds-only
        v_sec = 59; v_min = 59; v_hour = 23;
        step(1, 0, 0);
        check("cascade_hour_en", bus.hour_en, 1);
        step(0, 0, 0);
        check("cascade_off", bus.sec_en, 0);
        v_sec = 58;
        step(1, 0, 0);
        check("sec58_min_en", bus.min_en, 0);
        step(0, 0, 1);

        // SET_HOUR increments with wrap
        step(0, 1, 0);
        check("walk_fs1", bus.field_sel, 1);
        v_hour = 23;
        step(0, 0, 1);
        check("hour_wrap_load", bus.hour_load, 1);
        check("hour_wrap_data", bus.ld_data, 0);
        step(0, 0, 0);
        v_hour = 7;
        step(0, 0, 1);
        check("hour7_data", bus.ld_data, 8);
        step(1, 0, 0);
        check("set_no_sec_en", bus.sec_en, 0);

        // Mode walk; set+inc in SET_MIN advances without loading
        step(0, 1, 0);
        check("walk_fs2", bus.field_sel, 2);
        v_min = 59;
        step(0, 0, 1);
        check("min_wrap_data", bus.ld_data, 0);
        step(0, 1, 1);
        check("walk_fs3", bus.field_sel, 3);
        check("set_inc_no_load", bus.min_load, 0);
        step(0, 1, 0);
        check("walk_fs0", bus.field_sel, 0);

        // Blink in SET_SEC
        for (int k = 0; k < 3; k++) step(0, 1, 0);
        step(1, 0, 0);
        check("blink1", bus.blink, 1);
        step(0, 0, 0);
        step(1, 0, 0);
        check("blink0", bus.blink, 0);
        step(1, 0, 0);
        check("blink1b", bus.blink, 1);
        step(0, 1, 0);
        check("blink_run", bus.blink, 0);

        // Timeout in SET_MIN, restarted by a button on tick 9
        step(0, 1, 0);
        step(0, 1, 0);
        for (int k = 0; k < 8; k++) begin
            step(1, 0, 0);
            step(0, 0, 0);
        end
        v_min = 12;
        step(1, 0, 1);
        check("restart_load", bus.ld_data, 13);
        for (int k = 0; k < 10; k++) begin
            step(1, 0, 0);
            check("timeout_hold", bus.field_sel, 2);
        end
        step(0, 0, 0);
        check("timeout_run", bus.field_sel, 0);

        // Tick together with set_btn in SET_SEC is not forwarded
        for (int k = 0; k < 3; k++) step(0, 1, 0);
        step(1, 1, 0);
        check("sec_exit_no_en", bus.sec_en, 0);
        check("sec_exit_run", bus.field_sel, 0);

        // Async reset mid-SET_MIN with an increment pending
        step(0, 1, 0);
        step(0, 1, 0);
        v_min = 30;
        bus.min_val = 6'(v_min);
        bus.inc_btn = 1;
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check_all();
        check("rst_fs", bus.field_sel, 0);
        @(posedge clk); #1;
        check_all();
        bus.inc_btn = 0;
        rst_n = 1;
        @(posedge clk); #1;

        // Randomized traffic, limits favoured
        for (int n = 0; n < 600; n++) begin
            v_sec  = ($urandom_range(0, 3) == 0) ? 59 : int'($urandom_range(0, 59));
            v_min  = ($urandom_range(0, 3) == 0) ? 59 : int'($urandom_range(0, 59));
            v_hour = ($urandom_range(0, 3) == 0) ? 23 : int'($urandom_range(0, 23));
            step($urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 5) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
